// File: rtl/spi_ram_ctrl.sv
// Command-decoding single-port RAM behind the SPI slave: one command per rx_valid rising edge,
// with auto-incrementing write/read pointers. Define RAM_PARITY_EN to store and check even parity per word.
module spi_ram_ctrl #(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       seq_err,
    output logic       par_err
);

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    localparam logic [ADDR_SIZE-1:0] PTR_ONE = 1;

    logic [7:0]           memData [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_SIZE-1:0] rdPtr_q, rdPtr_d;
    logic                 waOk_q, waOk_d;
    logic                 raOk_q, raOk_d;
    logic                 rxValid_q;
    logic [7:0]           dout_q, dout_d;
    logic                 txValid_q, txValid_d;
    logic                 seqErr_q, seqErr_d;
    logic                 memWe;
    logic                 accept;
    cmd_e                 cmd;

`ifdef RAM_PARITY_EN
    logic                 memPar [MEM_DEPTH];
    logic                 parErr_q, parErr_d;
`endif

    assign cmd    = cmd_e'(din[9:8]);
    assign accept = rx_valid & ~rxValid_q;

    // Every accepted or rejected command drops tx_valid; only a legal RD_DATA re-raises it.
    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        waOk_d    = waOk_q;
        raOk_d    = raOk_q;
        dout_d    = dout_q;
        txValid_d = txValid_q;
        seqErr_d  = 1'b0;
        memWe     = 1'b0;
`ifdef RAM_PARITY_EN
        parErr_d  = parErr_q;
`endif
        if (accept) begin
            txValid_d = 1'b0;
`ifdef RAM_PARITY_EN
            parErr_d  = 1'b0;
`endif
            case (cmd)
                CMD_WR_ADDR: begin
                    wrPtr_d = din[ADDR_SIZE-1:0];
                    waOk_d  = 1'b1;
                end
                CMD_WR_DATA: begin
                    if (waOk_q) begin
                        memWe   = 1'b1;
                        wrPtr_d = wrPtr_q + PTR_ONE;
                    end else begin
                        seqErr_d = 1'b1;
                    end
                end
                CMD_RD_ADDR: begin
                    rdPtr_d = din[ADDR_SIZE-1:0];
                    raOk_d  = 1'b1;
                end
                CMD_RD_DATA: begin
                    if (raOk_q) begin
                        dout_d    = memData[rdPtr_q];
                        txValid_d = 1'b1;
                        rdPtr_d   = rdPtr_q + PTR_ONE;
`ifdef RAM_PARITY_EN
                        parErr_d  = memPar[rdPtr_q] != (^memData[rdPtr_q]);
`endif
                    end else begin
                        seqErr_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            waOk_q    <= 1'b0;
            raOk_q    <= 1'b0;
            rxValid_q <= 1'b0;
            dout_q    <= '0;
            txValid_q <= 1'b0;
            seqErr_q  <= 1'b0;
`ifdef RAM_PARITY_EN
            parErr_q  <= 1'b0;
`endif
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            waOk_q    <= waOk_d;
            raOk_q    <= raOk_d;
            rxValid_q <= rx_valid;
            dout_q    <= dout_d;
            txValid_q <= txValid_d;
            seqErr_q  <= seqErr_d;
`ifdef RAM_PARITY_EN
            parErr_q  <= parErr_d;
`endif
        end
    end

    // The array deliberately has no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (memWe) begin
            memData[wrPtr_q] <= din[7:0];
`ifdef RAM_PARITY_EN
            memPar[wrPtr_q]  <= ^din[7:0];
`endif
        end
    end

    assign dout     = dout_q;
    assign tx_valid = txValid_q;
    assign seq_err  = seqErr_q;
`ifdef RAM_PARITY_EN
    assign par_err  = parErr_q;
`else
    assign par_err  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed self-checking bench for spi_ram_ctrl; frames are driven on the falling edge
// and outputs sampled on the following falling edge.
module tb_spi_ram_ctrl;

    logic       clk;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;
    logic       seq_err;
    logic       par_err;

    int total = 0;
    int bad   = 0;

    spi_ram_ctrl #(.ADDR_SIZE(8), .MEM_DEPTH(256)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid),
        .seq_err  (seq_err),
        .par_err  (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one frame with rx_valid high for 'hold' cycles, then drop rx_valid.
    task automatic applyStimulus(input logic [9:0] frame, input int hold);
        @(negedge clk);
        din      = frame;
        rx_valid = 1'b1;
        repeat (hold) @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        din      = '0;
        rx_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_dout", {24'd0, dout}, 32'h0);
        checkOutput("rst_tx", {31'd0, tx_valid}, 32'h0);
        checkOutput("rst_seq", {31'd0, seq_err}, 32'h0);
        checkOutput("rst_par", {31'd0, par_err}, 32'h0);
        rst_n = 1'b1;

        // Basic write then read back
        applyStimulus(10'h000, 1);
        applyStimulus(10'h1A5, 1);
        applyStimulus(10'h200, 1);
        checkOutput("rdaddr_tx", {31'd0, tx_valid}, 32'h0);
        applyStimulus(10'h300, 1);
        checkOutput("basic_dout", {24'd0, dout}, 32'hA5);
        checkOutput("basic_tx", {31'd0, tx_valid}, 32'h1);
        checkOutput("basic_seq", {31'd0, seq_err}, 32'h0);
        applyStimulus(10'h000, 1);
        checkOutput("next_cmd_tx", {31'd0, tx_valid}, 32'h0);

        // Wrap of both pointers from 0xFF to 0x00
        applyStimulus(10'h0FF, 1);
        applyStimulus(10'h111, 1);
        applyStimulus(10'h122, 1);
        applyStimulus(10'h2FF, 1);
        applyStimulus(10'h300, 1);
        checkOutput("wrap_rd0", {24'd0, dout}, 32'h11);
        checkOutput("wrap_tx0", {31'd0, tx_valid}, 32'h1);
        applyStimulus(10'h300, 1);
        checkOutput("wrap_rd1", {24'd0, dout}, 32'h22);
        checkOutput("wrap_tx1", {31'd0, tx_valid}, 32'h1);

        // rx_valid held high must execute once
        applyStimulus(10'h010, 1);
        applyStimulus(10'h155, 12);
        checkOutput("hold_seq", {31'd0, seq_err}, 32'h0);
        applyStimulus(10'h166, 1);
        applyStimulus(10'h210, 1);
        applyStimulus(10'h300, 1);
        checkOutput("hold_rd10", {24'd0, dout}, 32'h55);
        applyStimulus(10'h300, 1);
        checkOutput("hold_rd11", {24'd0, dout}, 32'h66);

        // Same address rewritten returns the new data
        applyStimulus(10'h020, 1);
        applyStimulus(10'h13C, 1);
        applyStimulus(10'h220, 1);
        applyStimulus(10'h300, 1);
        checkOutput("same_rd_a", {24'd0, dout}, 32'h3C);
        applyStimulus(10'h020, 1);
        applyStimulus(10'h1C3, 1);
        applyStimulus(10'h220, 1);
        applyStimulus(10'h300, 1);
        checkOutput("same_rd_b", {24'd0, dout}, 32'hC3);

        // Writes between reads do not disturb rd_ptr
        applyStimulus(10'h040, 1);
        applyStimulus(10'h177, 1);
        applyStimulus(10'h188, 1);
        applyStimulus(10'h240, 1);
        applyStimulus(10'h199, 1);
        applyStimulus(10'h300, 1);
        checkOutput("indep_rd40", {24'd0, dout}, 32'h77);
        applyStimulus(10'h199, 1);
        applyStimulus(10'h300, 1);
        checkOutput("indep_rd41", {24'd0, dout}, 32'h88);

        // Out-of-order commands after reset, first one in the first post-reset cycle
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        din      = 10'h300;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        checkOutput("seq_rd_pulse", {31'd0, seq_err}, 32'h1);
        checkOutput("seq_rd_tx", {31'd0, tx_valid}, 32'h0);
        @(negedge clk);
        checkOutput("seq_rd_clear", {31'd0, seq_err}, 32'h0);
        applyStimulus(10'h1FF, 1);
        checkOutput("seq_wr_pulse", {31'd0, seq_err}, 32'h1);
        applyStimulus(10'h200, 1);
        checkOutput("seq_rdaddr_ok", {31'd0, seq_err}, 32'h0);
        applyStimulus(10'h300, 1);
        checkOutput("seq_nowrite", {24'd0, dout}, 32'h22);
        checkOutput("seq_read_tx", {31'd0, tx_valid}, 32'h1);
        applyStimulus(10'h1EE, 1);
        checkOutput("rej_clr_tx", {31'd0, tx_valid}, 32'h0);
        checkOutput("rej_seq", {31'd0, seq_err}, 32'h1);
        applyStimulus(10'h200, 1);
        applyStimulus(10'h300, 1);
        checkOutput("rej_nowrite", {24'd0, dout}, 32'h22);

        // Asynchronous reset in the middle of a frame while tx_valid is high
        @(negedge clk);
        din      = 10'h300;
        rx_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_tx", {31'd0, tx_valid}, 32'h0);
        checkOutput("async_dout", {24'd0, dout}, 32'h0);
        checkOutput("async_seq", {31'd0, seq_err}, 32'h0);
        @(negedge clk);
        rx_valid = 1'b0;
        rst_n    = 1'b1;
        applyStimulus(10'h210, 1);
        applyStimulus(10'h300, 1);
        checkOutput("keep_rd10", {24'd0, dout}, 32'h55);
        applyStimulus(10'h220, 1);
        applyStimulus(10'h300, 1);
        checkOutput("keep_rd20", {24'd0, dout}, 32'hC3);

        // Parity: stored bit is corrupted only when the feature exists
        applyStimulus(10'h004, 1);
        applyStimulus(10'h15A, 1);
        @(negedge clk);
`ifdef RAM_PARITY_EN
        dut.memPar[4] = ~dut.memPar[4];
`endif
        applyStimulus(10'h204, 1);
        applyStimulus(10'h300, 1);
        checkOutput("par_dout", {24'd0, dout}, 32'h5A);
        checkOutput("par_tx", {31'd0, tx_valid}, 32'h1);
`ifdef RAM_PARITY_EN
        checkOutput("par_err", {31'd0, par_err}, 32'h1);
`else
        checkOutput("par_err", {31'd0, par_err}, 32'h0);
`endif
        applyStimulus(10'h000, 1);
        checkOutput("par_clear", {31'd0, par_err}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
- Command-decoding single-port RAM placed directly downstream of the SPI slave.
- Consumes the slave's 10-bit rx_data/rx_valid frames: bits [9:8] carry the command, bits [7:0] carry the payload.
- Returns read data to the slave on dout/tx_valid for serialisation onto MISO.
- Holds separate auto-incrementing write and read address pointers and flags out-of-order command sequences.

Parameters:
- ADDR_SIZE, 8: address pointer width; must be <= 8.
- MEM_DEPTH, 256: number of 8-bit words; must equal 2**ADDR_SIZE.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- din  input  10  frame from SPI slave rx_data; [9:8] command, [7:0] payload.
- rx_valid  input  1  frame valid from SPI slave. Level signal; may stay high for many cycles per frame.
- dout  output  8  read data to SPI slave tx_data.
- tx_valid  output  1  dout valid to SPI slave.
- seq_err  output  1  one-cycle pulse when a command is rejected.
- par_err  output  1  parity mismatch on read data (see Optional Feature).

Behaviour:
- Reset: asynchronous, active-low.
  - Clocking and reset: single clock domain, clk.
  - On rst_n low, registers clear immediately: dout=0, tx_valid=0, seq_err=0, par_err=0, wr_ptr=0, rd_ptr=0, wa_ok=0, ra_ok=0, rx_valid_q=0.
  - Memory array is not reset; contents survive reset, including reset mid-frame.
- Command acceptance:
  - A command is accepted only on a rising edge of rx_valid: rx_valid=1 and rx_valid_q=0, where rx_valid_q is a registered copy.
  - Held-high rx_valid never re-executes a command.
  - At most one command is accepted per frame.
- Decode of accepted din[9:8]:
  - 00 WR_ADDR: wr_ptr <= din[ADDR_SIZE-1:0]; wa_ok <= 1.
  - 01 WR_DATA:
    - If wa_ok: mem[wr_ptr] <= din[7:0]; wr_ptr <= wr_ptr+1, wrapping modulo MEM_DEPTH.
    - Else: no write, seq_err pulses.
  - 10 RD_ADDR: rd_ptr <= din[ADDR_SIZE-1:0]; ra_ok <= 1; tx_valid <= 0.
  - 11 RD_DATA:
    - If ra_ok: dout <= mem[rd_ptr]; tx_valid <= 1; rd_ptr <= rd_ptr+1 (wrapping).
    - Else: seq_err pulses, dout/tx_valid unchanged.
- Read latency:
  - dout and tx_valid are registered and update on the same edge that accepts RD_DATA.
  - Both are visible 1 cycle after rx_valid rises.
- tx_valid lifetime:
  - Stays high, with dout stable, until the next accepted command of any type.
  - On that acceptance it deasserts in the same edge. Exception: an accepted RD_DATA reloads dout and keeps tx_valid high.
  - A rejected command also clears tx_valid.
- seq_err: high for exactly 1 cycle, the cycle after the rejected command's acceptance edge.
- Pointers:
  - wa_ok and ra_ok persist until reset; WR_DATA and RD_DATA may repeat after a single address command (burst via auto-increment).
  - wr_ptr and rd_ptr are independent; writing never moves rd_ptr.
  - Same-address write-then-read in consecutive frames returns the new data.
- Boundary conditions:
  - Pointer at MEM_DEPTH-1 followed by data command: access word MEM_DEPTH-1, pointer wraps to 0.
  - Payload bits above ADDR_SIZE are ignored for address commands.
  - rx_valid rising in the first cycle after reset deassertion is a valid acceptance.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - Each word stores a 9th bit, the even parity of the data, written on WR_DATA.
  - On RD_DATA, par_err <= (stored parity != ^mem data), registered alongside dout.
  - par_err holds while tx_valid is high and clears whenever tx_valid clears.
- Undefined:
  - No parity storage; par_err is tied to 0.
  - All other behaviour is identical.

Test Plan:
- Reset then frames 0x000 (WR_ADDR 0x00), 0x1A5 (WR_DATA 0xA5), 0x200 (RD_ADDR 0x00), 0x300 (RD_DATA) -> dout=0xA5 and tx_valid=1 one cycle after the 4th rx_valid rise.
- WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22; RD_ADDR 0xFF, RD_DATA x2 -> dout 0x11 then 0x22 (wrap from 0xFF to 0x00 in both pointers).
- Hold rx_valid high for 12 cycles on a single WR_DATA 0x155 frame after WR_ADDR 0x10 -> exactly one write (mem[0x10]=0x55); a following WR_DATA 0x166 lands at 0x11.
- After reset send RD_DATA 0x300 -> seq_err high 1 cycle, tx_valid stays 0; then WR_DATA 0x1FF -> seq_err pulses again and no memory change.
- Assert rst_n low mid-frame with tx_valid=1 -> tx_valid/dout/seq_err drop to 0 asynchronously; after release, RD_ADDR 0x00 and RD_DATA return the data written before reset.
- With RAM_PARITY_EN: write 0x5A to addr 0x04, force-flip the stored parity bit, read back -> dout=0x5A, par_err=1 with tx_valid. Without the macro, the same flow gives par_err=0.
